decode_stage: RTL and testbench

Registered RISC-V decode stage for the 3-stage core: decodes one 32-bit instruction per cycle into operands, ALU op, destination and branch information, and holds the result in an ID/EX pipeline register with a valid/ready handshake toward execution. It sits between the instruction fetch/ROM path and the execution unit, drives the register-file read addresses combinationally, and supports flush from taken branches. It succeeds the original ADDI/ADD/BNE-only combinational decoder with wider instruction coverage, parametrised data width, handshaking and optional write-back forwarding.

---
 rtl/decode_stage_pkg.sv | 60 ++++++
 rtl/decode_stage_if.sv | 34 +++
 rtl/decode_ctrl.sv | 118 +++++++++++
 rtl/decode_stage.sv | 162 ++++++++++++++++
 tb/tb_decode_stage.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg
// Shared definitions for the decode stage: RV32 opcode constants, funct3/funct7
// codes, the ALU operation encoding driven on ex_alu_op, and small helpers that
// map arithmetic funct3 codes onto ALU operations.
// No ports (package).
package decode_stage_pkg;

    // Major opcodes recognised by the decoder
    localparam logic [6:0] INST_TYPE_I   = 7'b0010011;
    localparam logic [6:0] INST_TYPE_R_M = 7'b0110011;
    localparam logic [6:0] INST_TYPE_B   = 7'b1100011;
    localparam logic [6:0] INST_LUI      = 7'b0110111;

    // funct3 codes
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;

    // funct7 codes
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // Operation code handed to the execution unit
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLT    = 4'd2,
        ALU_SLTU   = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_OR     = 4'd5,
        ALU_AND    = 4'd6,
        ALU_PASS_B = 4'd7,
        ALU_BEQ    = 4'd8,
        ALU_BNE    = 4'd9
    } alu_op_e;

    // True for the funct3 codes this core implements on I-type and R-type
    // arithmetic (shifts are not supported and decode as illegal).
    function automatic logic f3_is_arith(input logic [2:0] f3);
        return (f3 == F3_ADD_SUB) || (f3 == F3_SLT) || (f3 == F3_SLTU) ||
               (f3 == F3_XOR) || (f3 == F3_OR) || (f3 == F3_AND);
    endfunction

    function automatic alu_op_e f3_to_alu(input logic [2:0] f3);
        case (f3)
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_OR:   return ALU_OR;
            F3_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if
// ID/EX handshake bundle between the decode stage and the execution unit.
// master (decode): drives ex_valid and the ex_* payload, receives ex_ready.
// slave  (execute): receives ex_valid and the payload, drives ex_ready.
interface decode_stage_if
    import decode_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              ex_valid;
    logic              ex_ready;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_op1;
    logic [XLEN-1:0]   ex_op2;
    logic [XLEN-1:0]   ex_imm;
    alu_op_e           ex_alu_op;
    logic [REG_AW-1:0] ex_rd_addr;
    logic              ex_rd_wen;
    logic              ex_is_branch;
    logic              ex_illegal;

    modport master (
        output ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_alu_op,
               ex_rd_addr, ex_rd_wen, ex_is_branch, ex_illegal,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_pc, ex_op1, ex_op2, ex_imm, ex_alu_op,
               ex_rd_addr, ex_rd_wen, ex_is_branch, ex_illegal,
        output ex_ready
    );
endinterface

// File: rtl/decode_ctrl.sv
// decode_ctrl
// Purely combinational field decode of one 32-bit instruction.
// Ports:
//   inst        in   instruction word
//   alu_op      out  operation code for the execution unit
//   rs1_addr,
//   rs2_addr    out  register-file read addresses, 0 when the field is unused
//   rd_addr     out  destination register (0 when the instruction has none)
//   rd_wen      out  destination write enable (never set for rd=0)
//   op1_use_rs1 out  op1 takes rs1 data, otherwise 0
//   op2_use_rs2 out  op2 takes rs2 data, otherwise the immediate
//   imm         out  sign-extended immediate (0 when unused)
//   is_branch   out  conditional branch
//   illegal     out  unsupported encoding
module decode_ctrl
    import decode_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [31:0]       inst,
    output alu_op_e           alu_op,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    output logic [REG_AW-1:0] rd_addr,
    output logic              rd_wen,
    output logic              op1_use_rs1,
    output logic              op2_use_rs2,
    output logic [XLEN-1:0]   imm,
    output logic              is_branch,
    output logic              illegal
);
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [REG_AW-1:0] rs1_field;
    logic [REG_AW-1:0] rs2_field;
    logic [REG_AW-1:0] rd_field;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_u;
    logic [XLEN-1:0]   imm_b;

    assign opcode    = inst[6:0];
    assign funct3    = inst[14:12];
    assign funct7    = inst[31:25];
    assign rs1_field = REG_AW'(inst[19:15]);
    assign rs2_field = REG_AW'(inst[24:20]);
    assign rd_field  = REG_AW'(inst[11:7]);

    // Sign-extending size casts keep this correct for any XLEN >= 32
    assign imm_i = XLEN'($signed(inst[31:20]));
    assign imm_u = XLEN'($signed({inst[31:12], 12'b0}));
    assign imm_b = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));

    // Everything defaults to the "illegal" shape (all zero, no write) so an
    // unrecognised encoding only has to raise the illegal flag.
    always_comb begin
        alu_op      = ALU_ADD;
        rs1_addr    = '0;
        rs2_addr    = '0;
        rd_addr     = '0;
        rd_wen      = 1'b0;
        op1_use_rs1 = 1'b0;
        op2_use_rs2 = 1'b0;
        imm         = '0;
        is_branch   = 1'b0;
        illegal     = 1'b0;

        case (opcode)
            INST_TYPE_I: begin
                if (f3_is_arith(funct3)) begin
                    alu_op      = f3_to_alu(funct3);
                    rs1_addr    = rs1_field;
                    op1_use_rs1 = 1'b1;
                    imm         = imm_i;
                    rd_addr     = rd_field;
                    rd_wen      = (rd_field != '0);
                end else begin
                    illegal = 1'b1;
                end
            end
            INST_TYPE_R_M: begin
                if ((funct7 == F7_BASE && f3_is_arith(funct3)) ||
                    (funct7 == F7_SUB && funct3 == F3_ADD_SUB)) begin
                    alu_op      = (funct7 == F7_SUB) ? ALU_SUB : f3_to_alu(funct3);
                    rs1_addr    = rs1_field;
                    rs2_addr    = rs2_field;
                    op1_use_rs1 = 1'b1;
                    op2_use_rs2 = 1'b1;
                    rd_addr     = rd_field;
                    rd_wen      = (rd_field != '0);
                end else begin
                    illegal = 1'b1;
                end
            end
            INST_LUI: begin
                alu_op  = ALU_PASS_B;
                imm     = imm_u;
                rd_addr = rd_field;
                rd_wen  = (rd_field != '0);
            end
            INST_TYPE_B: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    alu_op      = (funct3 == F3_BNE) ? ALU_BNE : ALU_BEQ;
                    rs1_addr    = rs1_field;
                    rs2_addr    = rs2_field;
                    op1_use_rs1 = 1'b1;
                    op2_use_rs2 = 1'b1;
                    imm         = imm_b;
                    is_branch   = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage
// Registered decode stage: decodes one instruction per cycle and holds the
// result in an ID/EX register with a valid/ready handshake toward execution.
// Optional feature: define DECODE_FWD_EN to forward the write-back port onto
// the operands in the capture cycle; otherwise wb_* is ignored and the
// register file must be write-first.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   if_valid, id_ready  fetch-side handshake
//   inst, if_pc         instruction word and its address
//   rs1_addr, rs2_addr  combinational register-file read addresses
//   rs1_data, rs2_data  register-file read data
//   wb_wen/addr/data    write-back port (forwarding only)
//   flush               kill the held and the incoming instruction
//   ex                  ID/EX bundle (decode_stage_if master)
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    output logic              id_ready,
    input  logic [31:0]       inst,
    input  logic [XLEN-1:0]   if_pc,
    output logic [REG_AW-1:0] rs1_addr,
    output logic [REG_AW-1:0] rs2_addr,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              flush,
    decode_stage_if.master    ex
);
    alu_op_e           dec_alu_op;
    logic [REG_AW-1:0] dec_rd_addr;
    logic              dec_rd_wen;
    logic              dec_op1_use_rs1;
    logic              dec_op2_use_rs2;
    logic [XLEN-1:0]   dec_imm;
    logic              dec_is_branch;
    logic              dec_illegal;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic              accept;

    logic              ex_valid_q,     ex_valid_d;
    logic [XLEN-1:0]   ex_pc_q,        ex_pc_d;
    logic [XLEN-1:0]   ex_op1_q,       ex_op1_d;
    logic [XLEN-1:0]   ex_op2_q,       ex_op2_d;
    logic [XLEN-1:0]   ex_imm_q,       ex_imm_d;
    alu_op_e           ex_alu_op_q,    ex_alu_op_d;
    logic [REG_AW-1:0] ex_rd_addr_q,   ex_rd_addr_d;
    logic              ex_rd_wen_q,    ex_rd_wen_d;
    logic              ex_is_branch_q, ex_is_branch_d;
    logic              ex_illegal_q,   ex_illegal_d;

    decode_ctrl #(.XLEN(XLEN), .REG_AW(REG_AW)) u_ctrl (
        .inst        (inst),
        .alu_op      (dec_alu_op),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rd_addr     (dec_rd_addr),
        .rd_wen      (dec_rd_wen),
        .op1_use_rs1 (dec_op1_use_rs1),
        .op2_use_rs2 (dec_op2_use_rs2),
        .imm         (dec_imm),
        .is_branch   (dec_is_branch),
        .illegal     (dec_illegal)
    );

`ifdef DECODE_FWD_EN
    // x0 is never forwarded: a write-back addressed to x0 carries no value
    assign rs1_val = (wb_wen && wb_addr == rs1_addr && rs1_addr != '0) ? wb_data : rs1_data;
    assign rs2_val = (wb_wen && wb_addr == rs2_addr && rs2_addr != '0) ? wb_data : rs2_data;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_wen, wb_addr, wb_data};
    assign rs1_val   = rs1_data;
    assign rs2_val   = rs2_data;
`endif

    assign id_ready = !ex_valid_q || ex.ex_ready;
    assign accept   = if_valid && id_ready;

    // Load a new bundle on a transfer unless flush kills it; otherwise hold,
    // which keeps ex_* stable while execution stalls.
    always_comb begin
        ex_pc_d        = ex_pc_q;
        ex_op1_d       = ex_op1_q;
        ex_op2_d       = ex_op2_q;
        ex_imm_d       = ex_imm_q;
        ex_alu_op_d    = ex_alu_op_q;
        ex_rd_addr_d   = ex_rd_addr_q;
        ex_rd_wen_d    = ex_rd_wen_q;
        ex_is_branch_d = ex_is_branch_q;
        ex_illegal_d   = ex_illegal_q;

        if (accept && !flush) begin
            ex_pc_d        = if_pc;
            ex_op1_d       = dec_op1_use_rs1 ? rs1_val : '0;
            ex_op2_d       = dec_op2_use_rs2 ? rs2_val : dec_imm;
            ex_imm_d       = dec_imm;
            ex_alu_op_d    = dec_alu_op;
            ex_rd_addr_d   = dec_rd_addr;
            ex_rd_wen_d    = dec_rd_wen;
            ex_is_branch_d = dec_is_branch;
            ex_illegal_d   = dec_illegal;
        end

        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d = 1'b1;
        end else if (ex.ex_ready) begin
            ex_valid_d = 1'b0;
        end else begin
            ex_valid_d = ex_valid_q;
        end
    end

    // ID/EX pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_pc_q        <= '0;
            ex_op1_q       <= '0;
            ex_op2_q       <= '0;
            ex_imm_q       <= '0;
            ex_alu_op_q    <= ALU_ADD;
            ex_rd_addr_q   <= '0;
            ex_rd_wen_q    <= 1'b0;
            ex_is_branch_q <= 1'b0;
            ex_illegal_q   <= 1'b0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_pc_q        <= ex_pc_d;
            ex_op1_q       <= ex_op1_d;
            ex_op2_q       <= ex_op2_d;
            ex_imm_q       <= ex_imm_d;
            ex_alu_op_q    <= ex_alu_op_d;
            ex_rd_addr_q   <= ex_rd_addr_d;
            ex_rd_wen_q    <= ex_rd_wen_d;
            ex_is_branch_q <= ex_is_branch_d;
            ex_illegal_q   <= ex_illegal_d;
        end
    end

    assign ex.ex_valid     = ex_valid_q;
    assign ex.ex_pc        = ex_pc_q;
    assign ex.ex_op1       = ex_op1_q;
    assign ex.ex_op2       = ex_op2_q;
    assign ex.ex_imm       = ex_imm_q;
    assign ex.ex_alu_op    = ex_alu_op_q;
    assign ex.ex_rd_addr   = ex_rd_addr_q;
    assign ex.ex_rd_wen    = ex_rd_wen_q;
    assign ex.ex_is_branch = ex_is_branch_q;
    assign ex.ex_illegal   = ex_illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
// Self-checking bench for decode_stage. A table of decode vectors is streamed
// through the stage; expected ID/EX bundles go into a scoreboard queue when
// an instruction is accepted and are compared while the bundle is presented.
// Hand-written sequences cover stall, flush, reset mid-stall and forwarding
// (expectations follow DECODE_FWD_EN when it is defined).
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_valid;
    logic              id_ready;
    logic [31:0]       inst;
    logic [XLEN-1:0]   if_pc;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic              wb_wen;
    logic [REG_AW-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;
    logic              flush;

    decode_stage_if #(.XLEN(XLEN), .REG_AW(REG_AW)) ex_if ();

    decode_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_valid (if_valid),
        .id_ready (id_ready),
        .inst     (inst),
        .if_pc    (if_pc),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wb_wen   (wb_wen),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .flush    (flush),
        .ex       (ex_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        wen;
        logic        br;
        logic        ill;
    } bundle_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        bundle_t     exp;
    } vec_t;

    vec_t    vecs[11];
    vec_t    fwd_vec;
    bundle_t sb_q[$];
    int      pass_cnt = 0;
    int      chk_cnt  = 0;

    function automatic vec_t mk(input logic [31:0] i, pc, r1d, r2d,
                                input logic [4:0] r1a, r2a,
                                input logic [31:0] op1, op2, imm,
                                input logic [3:0] alu, input logic [4:0] rd,
                                input logic wen, br, ill);
        vec_t v;
        v.inst = i; v.rs1d = r1d; v.rs2d = r2d; v.rs1a = r1a; v.rs2a = r2a;
        v.exp.pc = pc; v.exp.op1 = op1; v.exp.op2 = op2; v.exp.imm = imm;
        v.exp.alu = alu; v.exp.rd = rd; v.exp.wen = wen; v.exp.br = br; v.exp.ill = ill;
        return v;
    endfunction

    function automatic bundle_t get_bundle();
        bundle_t b;
        b.pc  = ex_if.ex_pc;       b.op1 = ex_if.ex_op1;
        b.op2 = ex_if.ex_op2;      b.imm = ex_if.ex_imm;
        b.alu = ex_if.ex_alu_op;   b.rd  = ex_if.ex_rd_addr;
        b.wen = ex_if.ex_rd_wen;   b.br  = ex_if.ex_is_branch;
        b.ill = ex_if.ex_illegal;
        return b;
    endfunction

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Compare everything visible this cycle against the model
    task automatic check_output(input vec_t v, input bit ready);
        bit held;
        held = (sb_q.size() != 0);
        check("rs1_addr", rs1_addr, v.rs1a);
        check("rs2_addr", rs2_addr, v.rs2a);
        check("id_ready", id_ready, !held || ready);
        check("ex_valid", ex_if.ex_valid, held);
        if (held) check("ex_bundle", get_bundle(), sb_q[0]);
    endtask

    // Drive one cycle of stimulus at the falling edge, check, then update the
    // scoreboard with what the next rising edge will do.
    task automatic apply_stimulus(input vec_t v, input bit valid, input bit ready, input bit fl);
        bit held, acc;
        @(negedge clk);
        inst           = v.inst;
        if_pc          = v.exp.pc;
        rs1_data       = v.rs1d;
        rs2_data       = v.rs2d;
        if_valid       = valid;
        ex_if.ex_ready = ready;
        flush          = fl;
        #1;
        check_output(v, ready);
        held = (sb_q.size() != 0);
        acc  = valid && (!held || ready) && !fl;
        if (held && (ready || fl)) void'(sb_q.pop_front());
        if (acc) sb_q.push_back(v.exp);
    endtask

    initial begin
        vecs[0]  = mk(32'hFFF10093, 32'h100, 32'h5,  32'h77, 5'd2,  5'd0, 32'h5,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'd0, 5'd1, 1, 0, 0);
        vecs[1]  = mk(32'h405201B3, 32'h104, 32'hA,  32'h3,  5'd4,  5'd5, 32'hA,  32'h3,        32'h0,        4'd1, 5'd3, 1, 0, 0);
        vecs[2]  = mk(32'h00208033, 32'h108, 32'h11, 32'h22, 5'd1,  5'd2, 32'h11, 32'h22,       32'h0,        4'd0, 5'd0, 0, 0, 0);
        vecs[3]  = mk(32'hFE209CE3, 32'h10C, 32'hA,  32'hB,  5'd1,  5'd2, 32'hA,  32'hB,        32'hFFFFFFF8, 4'd9, 5'd0, 0, 1, 0);
        vecs[4]  = mk(32'h123452B7, 32'h110, 32'h99, 32'h88, 5'd0,  5'd0, 32'h0,  32'h12345000, 32'h12345000, 4'd7, 5'd5, 1, 0, 0);
        vecs[5]  = mk(32'hFFFFFFFF, 32'h114, 32'h99, 32'h88, 5'd0,  5'd0, 32'h0,  32'h0,        32'h0,        4'd0, 5'd0, 0, 0, 1);
        vecs[6]  = mk(32'h7FF43393, 32'h118, 32'h33, 32'h44, 5'd8,  5'd0, 32'h33, 32'h7FF,      32'h7FF,      4'd3, 5'd7, 1, 0, 0);
        vecs[7]  = mk(32'h00B574B3, 32'h11C, 32'hF0, 32'h3C, 5'd10, 5'd11, 32'hF0, 32'h3C,      32'h0,        4'd6, 5'd9, 1, 0, 0);
        vecs[8]  = mk(32'h00418863, 32'h120, 32'h1,  32'h2,  5'd3,  5'd4, 32'h1,  32'h2,        32'h10,       4'd8, 5'd0, 0, 1, 0);
        vecs[9]  = mk(32'h4020F1B3, 32'h124, 32'h1,  32'h2,  5'd0,  5'd0, 32'h0,  32'h0,        32'h0,        4'd0, 5'd0, 0, 0, 1);
        vecs[10] = mk(32'h8001C113, 32'h128, 32'h5,  32'h6,  5'd3,  5'd0, 32'h5,  32'hFFFFF800, 32'hFFFFF800, 4'd4, 5'd2, 1, 0, 0);

        rst = 1'b1; if_valid = 1'b0; inst = 32'h0; if_pc = '0;
        rs1_data = '0; rs2_data = '0; wb_wen = 1'b0; wb_addr = '0; wb_data = '0;
        flush = 1'b0; ex_if.ex_ready = 1'b0;

        // Reset state
        #2;
        check("rst_ex_valid", ex_if.ex_valid, 1'b0);
        check("rst_id_ready", id_ready, 1'b1);
        check("rst_bundle", get_bundle(), '0);
        @(posedge clk); #1 rst = 1'b0;

        // Back-to-back decode table at full throughput
        foreach (vecs[i]) apply_stimulus(vecs[i], 1'b1, 1'b1, 1'b0);
        repeat (2) apply_stimulus(vecs[0], 1'b0, 1'b1, 1'b0);

        // Stall three cycles with a pending instruction, then release
        apply_stimulus(vecs[0], 1'b1, 1'b1, 1'b0);
        repeat (3) apply_stimulus(vecs[1], 1'b1, 1'b0, 1'b0);
        apply_stimulus(vecs[1], 1'b1, 1'b1, 1'b0);
        apply_stimulus(vecs[2], 1'b1, 1'b1, 1'b0);
        repeat (2) apply_stimulus(vecs[2], 1'b0, 1'b1, 1'b0);

        // Flush while stalled with a held bundle and if_valid high
        apply_stimulus(vecs[3], 1'b1, 1'b1, 1'b0);
        apply_stimulus(vecs[4], 1'b1, 1'b0, 1'b1);
        apply_stimulus(vecs[5], 1'b1, 1'b1, 1'b0);
        apply_stimulus(vecs[6], 1'b1, 1'b1, 1'b1);
        repeat (2) apply_stimulus(vecs[6], 1'b0, 1'b1, 1'b0);

        // Asynchronous reset while stalled drops the held bundle
        apply_stimulus(vecs[7], 1'b1, 1'b1, 1'b0);
        apply_stimulus(vecs[8], 1'b1, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("midrst_ex_valid", ex_if.ex_valid, 1'b0);
        check("midrst_id_ready", id_ready, 1'b1);
        check("midrst_bundle", get_bundle(), '0);
        sb_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        apply_stimulus(vecs[8], 1'b1, 1'b1, 1'b0);
        repeat (2) apply_stimulus(vecs[8], 1'b0, 1'b1, 1'b0);

        // Write-back port: forwarded only with DECODE_FWD_EN, never for x0
        wb_wen = 1'b1; wb_addr = 5'd2; wb_data = 32'h1234;
`ifdef DECODE_FWD_EN
        fwd_vec = mk(32'h00110093, 32'h200, 32'h5, 32'h9, 5'd2, 5'd0, 32'h1234, 32'h1, 32'h1, 4'd0, 5'd1, 1, 0, 0);
`else
        fwd_vec = mk(32'h00110093, 32'h200, 32'h5, 32'h9, 5'd2, 5'd0, 32'h5,    32'h1, 32'h1, 4'd0, 5'd1, 1, 0, 0);
`endif
        apply_stimulus(fwd_vec, 1'b1, 1'b1, 1'b0);
        wb_addr = 5'd0;
        fwd_vec = mk(32'h00100093, 32'h204, 32'h55, 32'h9, 5'd0, 5'd0, 32'h55, 32'h1, 32'h1, 4'd0, 5'd1, 1, 0, 0);
        apply_stimulus(fwd_vec, 1'b1, 1'b1, 1'b0);
        wb_wen = 1'b0;
        repeat (2) apply_stimulus(fwd_vec, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
